// File: rtl/user_port_arbiter.sv
// Round-robin arbiter sharing one leaf_interface user port between NUM_REQ HLS
// output streams, with burst lock and a single registered output stage.
module user_port_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int REQ_IDX_BITS = 2,
  parameter int PAYLOAD_BITS = 32,
  parameter int MAX_BURST    = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_user2arb,
  input  logic [NUM_REQ-1:0]              vld_user2arb,
  output logic [NUM_REQ-1:0]              ack_arb2user,
  output logic [PAYLOAD_BITS-1:0]         dout_arb2interface,
  output logic                            vld_arb2interface,
  input  logic                            ack_interface2arb,
  output logic [REQ_IDX_BITS-1:0]         grant_idx,
  output logic                            busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [REQ_IDX_BITS-1:0] rr_ptr, rr_ptr_nxt;
  logic [REQ_IDX_BITS-1:0] grant_nxt;
  logic [REQ_IDX_BITS-1:0] grant_inc;
  logic [REQ_IDX_BITS-1:0] pick_idx;
  logic                    pick_found;
  logic [7:0]              burst_cnt, burst_nxt;
  logic                    can_load;
  logic                    take;
  logic                    burst_done;
  logic [PAYLOAD_BITS-1:0] req_word [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_split
    assign req_word[gi] = din_user2arb[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
  end

  // The output register may accept a new word when empty or draining this cycle.
  assign can_load   = !vld_arb2interface || ack_interface2arb;
  assign take       = (state == LOCKED) && vld_user2arb[grant_idx] && can_load;
  assign burst_done = ({1'b0, burst_cnt} + 9'd1) == 9'(MAX_BURST);
  assign grant_inc  = (grant_idx == REQ_IDX_BITS'(NUM_REQ - 1)) ?
                      '0 : grant_idx + REQ_IDX_BITS'(1);

  // First valid requester at or above rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    logic [REQ_IDX_BITS:0] cand;
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (REQ_IDX_BITS+1)'(k);
      if (cand >= (REQ_IDX_BITS+1)'(NUM_REQ)) cand = cand - (REQ_IDX_BITS+1)'(NUM_REQ);
      if (!pick_found && vld_user2arb[cand[REQ_IDX_BITS-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[REQ_IDX_BITS-1:0];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant_idx;
    burst_nxt  = burst_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_nxt = pick_idx;
          burst_nxt = '0;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        // Under backpressure the lock and counter are frozen whatever vld does.
        if (can_load) begin
          if (vld_user2arb[grant_idx]) begin
            burst_nxt = burst_cnt + 8'd1;
            if (burst_done) begin
              rr_ptr_nxt = grant_inc;
              state_nxt  = IDLE;
            end
          end else begin
            rr_ptr_nxt = grant_inc;
            state_nxt  = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack_arb2user = '0;
    if (take) ack_arb2user[grant_idx] = 1'b1;
    busy = (state == LOCKED) || vld_arb2interface;
  end

  // NOTE: reset is asynchronous and active-low, so it sits in the sensitivity list.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      rr_ptr             <= '0;
      grant_idx          <= '0;
      burst_cnt          <= '0;
      vld_arb2interface  <= 1'b0;
      dout_arb2interface <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      grant_idx <= grant_nxt;
      burst_cnt <= burst_nxt;
      if (take) begin
        dout_arb2interface <= req_word[grant_idx];
        vld_arb2interface  <= 1'b1;
      end else if (ack_interface2arb) begin
        vld_arb2interface  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_user_port_arbiter.sv
// Directed bench for user_port_arbiter: a MAX_BURST=8 instance and a MAX_BURST=1
// instance share the stimulus; a selector picks which one the sources talk to.
module tb_user_port_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [N*W-1:0] din;
  logic [N-1:0]   vld;
  logic           ack_if;
  logic [N-1:0]   ack_a, ack_b, ack_s;
  logic [W-1:0]   dout_a, dout_b, dout_s;
  logic           vo_a, vo_b, vo_s;
  logic [1:0]     g_a, g_b, g_s;
  logic           busy_a, busy_b, busy_s;
  logic           use_b;

  user_port_arbiter #(.NUM_REQ(N), .REQ_IDX_BITS(2), .PAYLOAD_BITS(W), .MAX_BURST(8)) dut_a (
    .clk(clk), .reset(reset), .din_user2arb(din), .vld_user2arb(vld), .ack_arb2user(ack_a),
    .dout_arb2interface(dout_a), .vld_arb2interface(vo_a), .ack_interface2arb(ack_if),
    .grant_idx(g_a), .busy(busy_a));

  user_port_arbiter #(.NUM_REQ(N), .REQ_IDX_BITS(2), .PAYLOAD_BITS(W), .MAX_BURST(1)) dut_b (
    .clk(clk), .reset(reset), .din_user2arb(din), .vld_user2arb(vld), .ack_arb2user(ack_b),
    .dout_arb2interface(dout_b), .vld_arb2interface(vo_b), .ack_interface2arb(ack_if),
    .grant_idx(g_b), .busy(busy_b));

  always_comb begin
    ack_s  = use_b ? ack_b  : ack_a;
    dout_s = use_b ? dout_b : dout_a;
    vo_s   = use_b ? vo_b   : vo_a;
    g_s    = use_b ? g_b    : g_a;
    busy_s = use_b ? busy_b : busy_a;
  end

  logic [W-1:0] src_word [N];
  int           src_left [N];
  logic [W-1:0] out_q [$];
  logic [W-1:0] exp_q [$];
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      vld[i]         = (src_left[i] > 0);
      din[i*W +: W]  = src_word[i];
    end
  endtask

  // One clock: record pre-edge handshakes, then advance sources that were acked.
  task automatic cycle();
    logic [N-1:0] a;
    #1;
    a = ack_s;
    if (vo_s && ack_if) out_q.push_back(dout_s);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (a[i]) begin
        src_word[i] = src_word[i] + 1;
        src_left[i] = src_left[i] - 1;
      end
    end
    drive();
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    ack_if = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_word[i] = '0;
      src_left[i] = 0;
    end
    drive();
    out_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
  endtask

  task automatic compare_queue(input string name);
    n_cmp++;
    if (out_q.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL %s count: got %0d expected %0d", name, out_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < out_q.size(); j++) begin
      n_cmp++;
      if (out_q[j] !== exp_q[j]) begin
        n_bad++;
        $display("FAIL %s word %0d: got %h expected %h", name, j, out_q[j], exp_q[j]);
      end
    end
  endtask

  task automatic test_reset();
    use_b  = 1'b0;
    reset  = 1'b0;
    ack_if = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_word[i] = '0;
      src_left[i] = 0;
    end
    drive();
    #3;
    n_cmp++; if (vo_s !== 1'b0) begin n_bad++; $display("FAIL reset vld: got %b expected 0", vo_s); end
    n_cmp++; if (dout_s !== '0) begin n_bad++; $display("FAIL reset dout: got %h expected 0", dout_s); end
    n_cmp++; if (busy_s !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b expected 0", busy_s); end
    n_cmp++; if (g_s !== 2'd0) begin n_bad++; $display("FAIL reset grant: got %0d expected 0", g_s); end
    n_cmp++; if (ack_s !== 4'b0) begin n_bad++; $display("FAIL reset ack: got %b expected 0000", ack_s); end
    #1 reset = 1'b1;
    #1;
  endtask

  task automatic test_single();
    do_reset();
    ack_if = 1'b1;
    src_word[1] = 32'h11;
    src_left[1] = 4;
    drive();
    cycle();
    n_cmp++; if (g_s !== 2'd1) begin n_bad++; $display("FAIL single grant: got %0d expected 1", g_s); end
    n_cmp++; if (ack_s !== 4'b0010) begin n_bad++; $display("FAIL single ack: got %b expected 0010", ack_s); end
    n_cmp++; if (vo_s !== 1'b0) begin n_bad++; $display("FAIL single vld early: got %b expected 0", vo_s); end
    for (int k = 0; k < 4; k++) begin
      cycle();
      n_cmp++;
      if (vo_s !== 1'b1 || dout_s !== 32'h11 + k) begin
        n_bad++;
        $display("FAIL single word %0d: got vld=%b dout=%h expected vld=1 dout=%h", k, vo_s, dout_s, 32'h11 + k);
      end
    end
    cycle();
    n_cmp++; if (vo_s !== 1'b0) begin n_bad++; $display("FAIL single drain vld: got %b expected 0", vo_s); end
    n_cmp++; if (busy_s !== 1'b0) begin n_bad++; $display("FAIL single idle busy: got %b expected 0", busy_s); end
    n_cmp++; if (out_q.size() !== 4) begin n_bad++; $display("FAIL single delivered: got %0d expected 4", out_q.size()); end
  endtask

  task automatic test_round_robin();
    do_reset();
    ack_if = 1'b1;
    for (int i = 0; i < N; i++) begin
      src_word[i] = W'(i) << 8;
      src_left[i] = 100;
    end
    drive();
    repeat (40) cycle();
    // Bursts of 8 with one grant cycle between them: loads at edges 2-9, 11-18, 20-27, 29-36, 38-39.
    exp_q.delete();
    for (int j = 0; j < 34; j++) exp_q.push_back((W'((j / 8) % 4) << 8) + W'(((j / 32) * 8) + (j % 8)));
    compare_queue("round_robin");
  endtask

  task automatic test_backpressure();
    do_reset();
    ack_if = 1'b1;
    src_word[0] = 32'hA00;
    src_left[0] = 20;
    drive();
    repeat (4) cycle();
    n_cmp++; if (dout_s !== 32'hA02) begin n_bad++; $display("FAIL bp before: got %h expected a02", dout_s); end
    ack_if = 1'b0;
    #1;
    n_cmp++; if (ack_s !== 4'b0) begin n_bad++; $display("FAIL bp ack comb: got %b expected 0000", ack_s); end
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_cmp++;
      if (dout_s !== 32'hA02 || vo_s !== 1'b1 || ack_s !== 4'b0) begin
        n_bad++;
        $display("FAIL bp hold %0d: got dout=%h vld=%b ack=%b expected a02 1 0000", k, dout_s, vo_s, ack_s);
      end
    end
    ack_if = 1'b1;
    repeat (5) cycle();
    n_cmp++; if (dout_s !== 32'hA07 || vo_s !== 1'b1) begin n_bad++; $display("FAIL bp resume: got dout=%h vld=%b expected a07 1", dout_s, vo_s); end
    cycle();
    // Eighth word of the burst ends it, so a bubble follows: counter was frozen during the stall.
    n_cmp++; if (vo_s !== 1'b0) begin n_bad++; $display("FAIL bp burst end bubble: got vld=%b expected 0", vo_s); end
    repeat (5) cycle();
    exp_q.delete();
    for (int j = 0; j < 12; j++) exp_q.push_back(32'hA00 + j);
    compare_queue("backpressure");
  endtask

  task automatic test_rearb();
    do_reset();
    ack_if = 1'b1;
    src_word[2] = 32'hB20; src_left[2] = 3;
    src_word[3] = 32'hB30; src_left[3] = 100;
    drive();
    repeat (5) cycle();
    n_cmp++; if (g_s !== 2'd2 || vo_s !== 1'b0 || busy_s !== 1'b0) begin
      n_bad++; $display("FAIL rearb release: got grant=%0d vld=%b busy=%b expected 2 0 0", g_s, vo_s, busy_s);
    end
    cycle();
    n_cmp++; if (g_s !== 2'd3) begin n_bad++; $display("FAIL rearb to req3: got %0d expected 3", g_s); end
    src_left[2] = 2;
    src_word[0] = 32'hB00; src_left[0] = 100;
    drive();
    repeat (9) cycle();
    n_cmp++; if (g_s !== 2'd0) begin n_bad++; $display("FAIL rearb wrap to req0: got %0d expected 0", g_s); end
    repeat (9) cycle();
    n_cmp++; if (g_s !== 2'd2) begin n_bad++; $display("FAIL rearb back to req2: got %0d expected 2", g_s); end
    repeat (3) cycle();
    exp_q.delete();
    for (int j = 0; j < 3; j++) exp_q.push_back(32'hB20 + j);
    for (int j = 0; j < 8; j++) exp_q.push_back(32'hB30 + j);
    for (int j = 0; j < 8; j++) exp_q.push_back(32'hB00 + j);
    exp_q.push_back(32'hB23);
    exp_q.push_back(32'hB24);
    compare_queue("rearb");
  endtask

  task automatic test_reset_mid();
    do_reset();
    ack_if = 1'b1;
    src_word[2] = 32'h22; src_left[2] = 1;
    drive();
    repeat (3) cycle();
    n_cmp++; if (g_s !== 2'd2 || vo_s !== 1'b0) begin n_bad++; $display("FAIL rmid setup: got grant=%0d vld=%b expected 2 0", g_s, vo_s); end
    ack_if = 1'b0;
    src_word[3] = 32'hDEADBEEF; src_left[3] = 5;
    drive();
    repeat (3) cycle();
    n_cmp++; if (dout_s !== 32'hDEADBEEF || vo_s !== 1'b1 || busy_s !== 1'b1 || ack_s !== 4'b0) begin
      n_bad++; $display("FAIL rmid held: got dout=%h vld=%b busy=%b ack=%b expected deadbeef 1 1 0000", dout_s, vo_s, busy_s, ack_s);
    end
    ack_if = 1'b1;
    #1;
    n_cmp++; if (ack_s !== 4'b1000) begin n_bad++; $display("FAIL rmid ack before reset: got %b expected 1000", ack_s); end
    reset = 1'b0;
    #1;
    n_cmp++; if (vo_s !== 1'b0 || busy_s !== 1'b0 || ack_s !== 4'b0 || dout_s !== '0) begin
      n_bad++; $display("FAIL rmid async clear: got vld=%b busy=%b ack=%b dout=%h expected 0 0 0000 0", vo_s, busy_s, ack_s, dout_s);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (vo_s !== 1'b0 || ack_s !== 4'b0) begin n_bad++; $display("FAIL rmid in reset: got vld=%b ack=%b expected 0 0000", vo_s, ack_s); end
    src_word[1] = 32'h51; src_left[1] = 3;
    drive();
    #1 reset = 1'b1;
    #1;
    out_q.delete();
    cycle();
    n_cmp++; if (g_s !== 2'd1) begin n_bad++; $display("FAIL rmid first grant: got %0d expected 1", g_s); end
    cycle();
    n_cmp++; if (dout_s !== 32'h51 || vo_s !== 1'b1) begin n_bad++; $display("FAIL rmid first word: got dout=%h vld=%b expected 51 1", dout_s, vo_s); end
  endtask

  task automatic test_max_burst_one();
    use_b = 1'b1;
    do_reset();
    ack_if = 1'b1;
    src_word[0] = 32'h600; src_left[0] = 100;
    src_word[1] = 32'h610; src_left[1] = 100;
    drive();
    for (int k = 1; k <= 10; k++) begin
      logic [1:0]   eg;
      logic         ev;
      logic [W-1:0] ed;
      cycle();
      eg = 2'(((k - 1) / 2) % 2);
      ev = (k % 2) == 0;
      ed = (((k / 2 - 1) % 2) == 1 ? 32'h610 : 32'h600) + W'((k / 2 - 1) / 2);
      n_cmp++;
      if (g_s !== eg || vo_s !== ev || (ev && dout_s !== ed)) begin
        n_bad++;
        $display("FAIL burst1 edge %0d: got grant=%0d vld=%b dout=%h expected %0d %b %h", k, g_s, vo_s, dout_s, eg, ev, ed);
      end
    end
    use_b = 1'b0;
  endtask

  initial begin
    use_b = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_rearb();
    test_reset_mid();
    test_max_burst_one();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/user_port_arbiter.md
Name: user_port_arbiter

Overview:
- Shares one leaf_interface user-side output port (32-bit payload, vld/ack) between NUM_REQ HLS operator output streams, e.g. several data_X_Y Output_n_V_V streams feeding one BFT output port.
- Round-robin arbitration with burst lock.
- Single registered output stage giving 1 word/cycle throughput.
- Sits between the HLS operator(s) and leaf_interface inside a page top.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- REQ_IDX_BITS, 2, width of requester index; must equal clog2(NUM_REQ).
- PAYLOAD_BITS, 32, word width.
- MAX_BURST, 8, maximum consecutive words granted to one requester before forced re-arbitration (1..255).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- din_user2arb  in  NUM_REQ*PAYLOAD_BITS  requester words; requester i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- vld_user2arb  in  NUM_REQ  requester valid (ap_vld).
- ack_arb2user  out  NUM_REQ  per-requester accept (ap_ack); combinational.
- dout_arb2interface  out  PAYLOAD_BITS  word to leaf_interface din_leaf_user2interface.
- vld_arb2interface  out  1  output valid.
- ack_interface2arb  in  1  leaf_interface accept.
- grant_idx  out  REQ_IDX_BITS  current or last granted requester.
- busy  out  1  high in state LOCKED or while vld_arb2interface is high.

Behaviour:
- Transfer rules:
  - A user-side transfer occurs on a cycle where vld_user2arb[i] && ack_arb2user[i] are both high.
  - An output transfer occurs on a cycle where vld_arb2interface && ack_interface2arb are both high.
- Output register:
  - can_load = !vld_arb2interface || ack_interface2arb.
  - When a word is accepted at cycle t, dout/vld are updated at edge t+1; latency is 1 cycle.
  - When vld_arb2interface=1 and ack_interface2arb=0, dout holds stable.
  - vld_arb2interface clears after an output transfer with no new load.
- ack_arb2user[i] = (state==LOCKED) && (grant_idx==i) && vld_user2arb[i] && can_load. At most one bit is high per cycle.
- State machine:
  - IDLE:
    - If any vld is high, pick the first requester with vld high, searching from rr_ptr upward with wrap at NUM_REQ-1 -> 0.
    - Load grant_idx, clear burst_cnt, go to LOCKED. No ack is issued in this cycle; the grant decision costs 1 cycle.
    - If no vld is high, stay in IDLE.
  - LOCKED:
    - On each accepted word, burst_cnt increments.
    - If burst_cnt+1 == MAX_BURST on an accept, set rr_ptr = grant_idx+1 (wrapped) and go to IDLE.
    - If vld_user2arb[grant_idx]==0 and can_load==1, set rr_ptr = grant_idx+1 (wrapped) and go to IDLE with no word taken.
    - If can_load==0, hold: no ack, counters frozen, lock retained regardless of vld.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0 in bursts of MAX_BURST words.
- MAX_BURST=1: the state machine alternates IDLE/LOCKED, giving 1 word per 2 cycles per grant (accepted throughput limit).
- Simultaneous events: an output drain and a new load in the same cycle are allowed (can_load=1); the new word replaces the old one at the edge.
- Reset values: state=IDLE, rr_ptr=0, grant_idx=0, burst_cnt=0, vld_arb2interface=0, dout_arb2interface=0, busy=0, ack_arb2user=0.
- Reset mid-operation: any buffered word is discarded (not delivered). Requesters see no ack while reset is low.
- Words from one requester are never reordered. Words are never dropped or duplicated outside of reset.

Test Plan:
- Single requester: req1 streams 0x11..0x14 with vld held and interface ack=1 -> grant_idx=1 after 1 cycle, dout 0x11,0x12,0x13,0x14 on consecutive cycles, each 1 cycle after its ack.
- All 4 requesters continuously valid, MAX_BURST=8, ack=1 -> output contains 8 words from req0, then 8 from req1, 8 from req2, 8 from req3, then back to req0. One bubble cycle appears at each switch.
- Backpressure: ack_interface2arb low for 5 cycles mid-burst -> dout and vld held stable, ack_arb2user=0, burst_cnt frozen. On release, the stream resumes with no loss or duplicate.
- req2 drops vld after 3 words while req3 is valid -> re-arbitration, grant_idx=3, rr_ptr=3. req2's next burst waits until req3 (and req0/req1 if valid) have been served.
- Assert reset low while vld_arb2interface=1 holding 0xDEADBEEF -> vld, busy and ack clear immediately (asynchronously). After release, the first grant goes to the lowest-index valid requester starting from 0.
- MAX_BURST=1 with req0 and req1 valid -> output alternates req0/req1 words, one word every 2 cycles.
